// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin constants for the vending dispense controller
//
// Purpose: one place for the controller state codes, the coin values in
// quarter units and the default product price, so the top level and any
// future front-panel logic agree on them.
package vend_pkg;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] vend_state_t;

    // Controller states
    localparam vend_state_t ST_IDLE     = 2'd0;
    localparam vend_state_t ST_CREDIT   = 2'd1;
    localparam vend_state_t ST_DISPENSE = 2'd2;
    localparam vend_state_t ST_CHANGE   = 2'd3;

    // Coin values in quarters
    localparam int unsigned Q_VAL = 1;
    localparam int unsigned D_VAL = 4;

    // Default product price in quarters (0.75$)
    localparam int unsigned PRICE_Q_DEF = 3;

    // The machine is busy while a bottle is being dropped or change is paid out.
    function automatic logic state_is_busy(input vend_state_t st);
        return (st == ST_DISPENSE) || (st == ST_CHANGE);
    endfunction

endpackage

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable/clearable saturating cycle counter with terminal-count flag
//
// Purpose: counts clk cycles while enabled; tc_o is high once the count has
// reached TERM-1. The count saturates at all-ones so it can never wrap back
// below the terminal value.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset, count -> 0
//   clr_i       synchronous clear (highest priority)
//   en_i        count enable
//   load_i      synchronous load of load_val_i
//   load_val_i  value loaded when load_i is high
//   tc_o        terminal count reached (count >= TERM-1)
module vend_timer #(
    parameter  int unsigned TERM = 1024,
    localparam int unsigned TW   = (TERM > 2) ? $clog2(TERM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          tc_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {TW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q >= TW'(TERM - 1));

endmodule

// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - credit and dispense sequencer for the water vending machine
//
// Purpose: accumulates coin credit in quarters, arbitrates coin entry,
// product selection and cancel, handshakes with the bottle dispenser and
// pays change back as one quarter pulse per cycle. All outputs are registered.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   coin_q_i       one-cycle pulse: quarter inserted
//   coin_d_i       one-cycle pulse: dollar inserted (4 quarters)
//   select_i       one-cycle pulse: buy request
//   cancel_i       one-cycle pulse: refund request
//   disp_ack_i     dispenser done, level sampled every cycle
//   disp_req_o     dispense request, held until ack or timeout
//   chg_pulse_o    one-cycle pulse per quarter returned
//   coin_reject_o  one-cycle pulse: coin returned, not credited
//   fault_o        one-cycle pulse: dispenser ack timeout
//   busy_o         high while dispensing or paying change
//   credit_o       current credit in quarters
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_Q      = PRICE_Q_DEF,
    parameter int unsigned MAX_CREDIT_Q = 8,
    parameter int unsigned TIMEOUT_CYC  = 1024,
    parameter int unsigned CW           = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coin_q_i,
    input  logic          coin_d_i,
    input  logic          select_i,
    input  logic          cancel_i,
    input  logic          disp_ack_i,
    output logic          disp_req_o,
    output logic          chg_pulse_o,
    output logic          coin_reject_o,
    output logic          fault_o,
    output logic          busy_o,
    output logic [CW-1:0] credit_o
);

    localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_CREDIT_Q);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE_Q);

    vend_state_t   state_q,  state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          disp_req_q, chg_q, reject_q, fault_q, busy_q;
    logic          chg_d, reject_d, fault_d;

    logic          tmr_clr, tmr_en, tmr_tc;

    logic [CW:0]   sum_dol, sum_qtr;
    logic          coin_window, acc_dol, acc_qtr, coin_acc;
    logic [CW-1:0] coin_sum;
    logic [CW-1:0] remain;

    // One timer serves both the idle-credit timeout and the dispenser ack
    // timeout; it is cleared on every state change so each phase starts at 0.
    vend_timer #(
        .TERM (TIMEOUT_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (tmr_clr),
        .en_i       (tmr_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (tmr_tc)
    );

    assign tmr_en = (state_q == ST_CREDIT) || (state_q == ST_DISPENSE);

    // Sums are one bit wider than credit so an over-limit coin is detected
    // instead of wrapping.
    assign sum_dol = {1'b0, credit_q} + (CW+1)'(D_VAL);
    assign sum_qtr = {1'b0, credit_q} + (CW+1)'(Q_VAL);

    // Coins are only credited while the machine is taking money and no
    // refund (cancel or idle timeout) is starting in the same cycle.
    assign coin_window = (state_q == ST_IDLE) ||
                         ((state_q == ST_CREDIT) && !cancel_i && !tmr_tc);

    // A dollar wins over a simultaneous quarter; the quarter is returned.
    assign acc_dol  = coin_window && coin_d_i && (sum_dol <= MAX_C);
    assign acc_qtr  = coin_window && coin_q_i && !coin_d_i && (sum_qtr <= MAX_C);
    assign coin_acc = acc_dol || acc_qtr;
    assign coin_sum = acc_dol ? sum_dol[CW-1:0] : sum_qtr[CW-1:0];
    assign reject_d = (coin_d_i && !acc_dol) || (coin_q_i && !acc_qtr);

    // Credit left after paying for a bottle; clamped so it can never wrap.
    assign remain = (credit_q >= PRICE_C) ? (credit_q - PRICE_C) : '0;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        chg_d    = 1'b0;
        fault_d  = 1'b0;
        tmr_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (coin_acc) begin
                    credit_d = coin_sum;
                    state_d  = ST_CREDIT;
                end
            end

            ST_CREDIT: begin
                if (cancel_i || tmr_tc) begin
                    state_d = ST_CHANGE;
                    tmr_clr = 1'b1;
                end else begin
                    // A coin arriving with a winning select is still credited;
                    // the price check uses the credit held before this cycle.
                    if (coin_acc) begin
                        credit_d = coin_sum;
                    end
                    if (select_i && (credit_q >= PRICE_C)) begin
                        state_d = ST_DISPENSE;
                    end
                    // Any user activity, even a rejected-price select,
                    // restarts the idle timeout.
                    tmr_clr = coin_acc || select_i;
                end
            end

            ST_DISPENSE: begin
                if (disp_ack_i) begin
                    credit_d = remain;
                    state_d  = (remain != '0) ? ST_CHANGE : ST_IDLE;
                    tmr_clr  = 1'b1;
                end else if (tmr_tc) begin
                    // No bottle came out: refund everything, keep price.
                    fault_d = 1'b1;
                    state_d = ST_CHANGE;
                    tmr_clr = 1'b1;
                end
            end

            ST_CHANGE: begin
                tmr_clr = 1'b1;
                if (credit_q != '0) begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tmr_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            disp_req_q <= 1'b0;
            chg_q      <= 1'b0;
            reject_q   <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            disp_req_q <= (state_d == ST_DISPENSE);
            chg_q      <= chg_d;
            reject_q   <= reject_d;
            fault_q    <= fault_d;
            busy_q     <= state_is_busy(state_d);
        end
    end

    assign disp_req_o    = disp_req_q;
    assign chg_pulse_o   = chg_q;
    assign coin_reject_o = reject_q;
    assign fault_o       = fault_q;
    assign busy_o        = busy_q;
    assign credit_o      = credit_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb/tb_vend_dispense_ctrl.sv - self-checking bench for vend_dispense_ctrl
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_q_i, coin_d_i, select_i, cancel_i, disp_ack_i;
    logic       disp_req_o, chg_pulse_o, coin_reject_o, fault_o, busy_o;
    logic [3:0] credit_o;

    always #5 clk = ~clk;

    vend_dispense_ctrl #(
        .PRICE_Q      (3),
        .MAX_CREDIT_Q (8),
        .TIMEOUT_CYC  (1024),
        .CW           (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_q_i      (coin_q_i),
        .coin_d_i      (coin_d_i),
        .select_i      (select_i),
        .cancel_i      (cancel_i),
        .disp_ack_i    (disp_ack_i),
        .disp_req_o    (disp_req_o),
        .chg_pulse_o   (chg_pulse_o),
        .coin_reject_o (coin_reject_o),
        .fault_o       (fault_o),
        .busy_o        (busy_o),
        .credit_o      (credit_o)
    );

    // in  = {coin_q, coin_d, select, cancel, disp_ack}
    // out = {disp_req, chg_pulse, coin_reject, fault, busy}
    typedef struct {
        logic [4:0] in;
        logic [4:0] out;
        logic [3:0] cr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t V(input logic [4:0] i, input logic [4:0] o, input int c);
        vec_t v;
        v.in  = i;
        v.out = o;
        v.cr  = 4'(c);
        return v;
    endfunction

    task automatic idle_inputs();
        {coin_q_i, coin_d_i, select_i, cancel_i, disp_ack_i} = 5'b00000;
    endtask

    task automatic drive(input vec_t v);
        {coin_q_i, coin_d_i, select_i, cancel_i, disp_ack_i} = v.in;
        sb.push_back(v);
    endtask

    task automatic compare_now(input int tag);
        vec_t       e;
        logic [4:0] act;
        e   = sb.pop_front();
        act = {disp_req_o, chg_pulse_o, coin_reject_o, fault_o, busy_o};
        n_vec++;
        if ((act !== e.out) || (credit_o !== e.cr)) begin
            n_err++;
            $display("FAIL vec%0d req/chg/rej/flt/busy=%b credit=%0d, want %b credit=%0d",
                     tag, act, credit_o, e.out, e.cr);
        end
    endtask

    task automatic step(input vec_t v, input int tag);
        drive(v);
        @(posedge clk);
        #1;
        compare_now(tag);
    endtask

    task automatic chk(input string name, input int got, input int lo, input int hi);
        n_vec++;
        if ((got < lo) || (got > hi)) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
        end
    endtask

    initial begin
        int k;
        int n;

        idle_inputs();

        // select / cancel in IDLE are ignored
        tbl.push_back(V(5'b00100, 5'b00000, 0));
        tbl.push_back(V(5'b00010, 5'b00000, 0));
        // three quarters, select, quarter during dispense rejected, ack -> IDLE
        tbl.push_back(V(5'b10000, 5'b00000, 1));
        tbl.push_back(V(5'b10000, 5'b00000, 2));
        tbl.push_back(V(5'b10000, 5'b00000, 3));
        tbl.push_back(V(5'b00100, 5'b10001, 3));
        tbl.push_back(V(5'b10000, 5'b10101, 3));
        tbl.push_back(V(5'b00001, 5'b00000, 0));
        tbl.push_back(V(5'b00000, 5'b00000, 0));
        // dollar, select, ack -> one quarter change
        tbl.push_back(V(5'b01000, 5'b00000, 4));
        tbl.push_back(V(5'b00100, 5'b10001, 4));
        tbl.push_back(V(5'b00001, 5'b00001, 1));
        tbl.push_back(V(5'b00000, 5'b01000, 0));
        tbl.push_back(V(5'b00000, 5'b00000, 0));
        // quarter together with a winning select is still credited
        tbl.push_back(V(5'b10000, 5'b00000, 1));
        tbl.push_back(V(5'b10000, 5'b00000, 2));
        tbl.push_back(V(5'b10000, 5'b00000, 3));
        tbl.push_back(V(5'b10100, 5'b10001, 4));
        tbl.push_back(V(5'b00001, 5'b00001, 1));
        tbl.push_back(V(5'b00000, 5'b01000, 0));
        // two dollars fill to the limit, quarter rejected, cancel refunds 8
        tbl.push_back(V(5'b01000, 5'b00000, 4));
        tbl.push_back(V(5'b01000, 5'b00000, 8));
        tbl.push_back(V(5'b10000, 5'b00100, 8));
        tbl.push_back(V(5'b00010, 5'b00001, 8));
        tbl.push_back(V(5'b10000, 5'b01101, 7));
        tbl.push_back(V(5'b00110, 5'b01001, 6));
        for (int c = 5; c >= 1; c--) tbl.push_back(V(5'b00000, 5'b01001, c));
        tbl.push_back(V(5'b00000, 5'b01000, 0));
        tbl.push_back(V(5'b00000, 5'b00000, 0));
        // dollar that would exceed the limit is rejected, refund of 5
        tbl.push_back(V(5'b10000, 5'b00000, 1));
        tbl.push_back(V(5'b01000, 5'b00000, 5));
        tbl.push_back(V(5'b01000, 5'b00100, 5));
        tbl.push_back(V(5'b00010, 5'b00001, 5));
        for (int c = 4; c >= 1; c--) tbl.push_back(V(5'b00000, 5'b01001, c));
        tbl.push_back(V(5'b00000, 5'b01000, 0));
        tbl.push_back(V(5'b00000, 5'b00000, 0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        drive(V(5'b00000, 5'b00000, 0));
        compare_now(999);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], i);

        // select below price ignored, then idle-credit timeout refunds 2
        step(V(5'b10000, 5'b00000, 1), 100);
        step(V(5'b10000, 5'b00000, 2), 101);
        step(V(5'b00100, 5'b00000, 2), 102);
        idle_inputs();
        k = 0;
        while (!chg_pulse_o && (k < 1200)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_timeout_cycles", k, 1020, 1030);
        n = 0;
        while (chg_pulse_o && (n < 20)) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("idle_refund_pulses", n, 2, 2);
        chk("idle_refund_credit", int'(credit_o), 0, 0);
        chk("idle_refund_busy", int'(busy_o), 0, 0);

        // dispenser never acks: fault, full refund of 3
        step(V(5'b10000, 5'b00000, 1), 110);
        step(V(5'b10000, 5'b00000, 2), 111);
        step(V(5'b10000, 5'b00000, 3), 112);
        step(V(5'b00100, 5'b10001, 3), 113);
        idle_inputs();
        k = 0;
        while (!fault_o && (k < 1200)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ack_timeout_cycles", k, 1020, 1030);
        chk("fault_req_dropped", int'(disp_req_o), 0, 0);
        chk("fault_credit_kept", int'(credit_o), 3, 3);
        chk("fault_busy", int'(busy_o), 1, 1);
        chk("fault_no_chg_yet", int'(chg_pulse_o), 0, 0);
        @(posedge clk);
        #1;
        chk("fault_single_pulse", int'(fault_o), 0, 0);
        n = 0;
        while (chg_pulse_o && (n < 20)) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("fault_refund_pulses", n, 3, 3);
        chk("fault_refund_credit", int'(credit_o), 0, 0);

        // dollar and quarter together, then reset in the middle of a dispense
        step(V(5'b11000, 5'b00100, 4), 120);
        step(V(5'b00100, 5'b10001, 4), 121);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        drive(V(5'b00000, 5'b00000, 0));
        compare_now(122);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(V(5'b00000, 5'b00000, 0), 123);
        step(V(5'b10000, 5'b00000, 1), 124);
        step(V(5'b00010, 5'b00001, 1), 125);
        step(V(5'b00000, 5'b01000, 0), 126);
        step(V(5'b00000, 5'b00000, 0), 127);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Credit-and-dispense sequencer for the water vending machine. It accumulates coin credit in quarter units, arbitrates between coin entry, product selection and cancel, and handshakes with the bottle dispenser mechanism. It then returns change as one quarter pulse per cycle. It sits between the coin acceptor and front panel on one side and the dispenser motor and change hopper on the other.

Parameters:
PRICE_Q, 3, product price in quarters (0.75$)
MAX_CREDIT_Q, 8, maximum credit held in quarters; a coin that would exceed it is rejected
TIMEOUT_CYC, 1024, idle-credit timeout and dispenser-ack timeout, in clk cycles
CW, 4, credit counter width; must satisfy 2^CW > MAX_CREDIT_Q

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
coin_q  in  1  one-cycle pulse: quarter inserted
coin_d  in  1  one-cycle pulse: dollar inserted (4 quarters)
select  in  1  one-cycle pulse: buy request
cancel  in  1  one-cycle pulse: refund request
disp_ack  in  1  dispenser done; level, sampled each cycle
disp_req  out  1  dispense request, held until ack or timeout
chg_pulse  out  1  one-cycle pulse per quarter returned
coin_reject  out  1  one-cycle pulse: coin returned to user, not credited
fault  out  1  one-cycle pulse: dispenser ack timeout
busy  out  1  high in DISPENSE or CHANGE
credit  out  CW  current credit in quarters

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-dispense): state=IDLE, credit=0, timer=0. disp_req, chg_pulse, coin_reject, fault and busy are all 0.
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- Coin add, allowed in IDLE and CREDIT only:
  - coin_d adds 4; coin_q adds 1.
  - If coin_d and coin_q arrive in the same cycle, the dollar is processed and the quarter is rejected.
  - If credit + value > MAX_CREDIT_Q, that coin is rejected and credit is unchanged.
  - Any coin in DISPENSE or CHANGE is rejected.
  - coin_reject is asserted in the cycle after the offending pulse.
- IDLE -> CREDIT on the first accepted coin.
- CREDIT:
  - The timer clears on every accepted coin or select, and increments otherwise.
  - select with credit >= PRICE_Q -> DISPENSE, with disp_req=1 from the next cycle.
  - select with credit < PRICE_Q is ignored (no state change; the timer still clears).
  - cancel -> CHANGE (full refund).
  - Timer reaching TIMEOUT_CYC-1 -> CHANGE (full refund).
  - Priority in the same cycle: cancel > select > coin.
  - A coin accepted in the same cycle as a winning select is still credited.
- DISPENSE:
  - disp_req is held at 1 and the timer counts.
  - On disp_ack=1: credit -= PRICE_Q and disp_req drops next cycle. Go to CHANGE if the remaining credit > 0, else IDLE.
  - On timer reaching TIMEOUT_CYC-1 without ack: fault pulses, disp_req drops, credit is not deducted, go to CHANGE (full refund).
- CHANGE:
  - One chg_pulse per cycle; credit decrements by 1 per pulse.
  - The pulse that takes credit to 0 is the last; the next state is IDLE.
  - A refund of N quarters produces exactly N consecutive pulses.
  - cancel and select are ignored.
- Latency: accepted coin -> credit updated next cycle. select -> disp_req the next cycle. disp_ack -> first chg_pulse 2 cycles later.
- credit never exceeds MAX_CREDIT_Q and never underflows; the CW width is sufficient by the parameter rule.
- busy = (state==DISPENSE || state==CHANGE).

Decomposition:
- Shared package vend_pkg: state enum (IDLE, CREDIT, DISPENSE, CHANGE), coin value constants (Q_VAL=1, D_VAL=4), default PRICE_Q.
- One sub-module, vend_timer: loadable/clearable saturating cycle counter with a terminal-count flag. It is reused for both the idle timeout and the ack timeout.

Test Plan:
- Quarter x3, select, disp_ack 2 cycles after disp_req -> credit 1,2,3; disp_req=1; credit 0; no chg_pulse; back to IDLE.
- Dollar, select, ack -> credit 4 then 1; exactly 1 chg_pulse; IDLE; busy high from DISPENSE entry until the chg_pulse.
- Dollar x2 then a quarter (MAX_CREDIT_Q=8) -> credit 8; the quarter gets coin_reject=1 and credit stays 8. Cancel -> 8 consecutive chg_pulse.
- Quarter x2 then select -> ignored, credit 2. No activity for 1024 cycles -> 2 chg_pulse, IDLE.
- Credit 3, select, no disp_ack for 1024 cycles -> fault pulse; disp_req drops; 3 chg_pulse; credit 0.
- coin_d and coin_q in the same cycle -> credit +4 and coin_reject=1. rst_n low during DISPENSE -> disp_req=0, credit=0, IDLE immediately.
